// File: rtl/cl_dmem_ctrl.sv
// Data-memory sequencer: one outstanding load/store, byte lane formatting,
// misaligned word rejection and a saturating stall-cycle counter.
module cl_dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic        is_byte_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  output logic [31:0] stall_cycles_o,
  output logic        dmem_valid_o,
  output logic        dmem_we_o,
  output logic [29:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_yumi_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        is_byte_q, is_byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        misal_q, misal_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] rdata_shift;
  logic [31:0] rdata_fmt;
  logic        misal_in;

  assign misal_in    = !is_byte_i && (addr_i[1:0] != 2'b00);
  assign rdata_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
  assign rdata_fmt   = is_byte_q ? {24'b0, rdata_shift[7:0]} : dmem_rdata_i;

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    is_byte_d  = is_byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    misal_d    = misal_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          is_store_d = is_store_i;
          is_byte_d  = is_byte_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          misal_d    = misal_in;
          if (misal_in) begin
            // A rejected op leaves a zero result behind.
            rdata_d = 32'b0;
            state_d = StDone;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_yumi_i) begin
          state_d = is_store_q ? StDone : StWait;
        end
      end
      StWait: begin
        if (dmem_rvalid_i) begin
          rdata_d = rdata_fmt;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall_o = ((state_q == StIdle) && req_valid_i) || (state_q == StReq) ||
                   (state_q == StWait);

  assign stall_cnt_d = (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                   : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      is_byte_q   <= 1'b0;
      addr_q      <= 32'b0;
      wdata_q     <= 32'b0;
      misal_q     <= 1'b0;
      rdata_q     <= 32'b0;
      stall_cnt_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      is_byte_q   <= is_byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      misal_q     <= misal_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    dmem_valid_o = (state_q == StReq);
    dmem_we_o    = dmem_valid_o && is_store_q;
    dmem_addr_o  = addr_q[31:2];
    dmem_wdata_o = is_byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    dmem_be_o    = 4'b0000;
    if (dmem_valid_o) begin
      dmem_be_o = is_byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
    end
  end

  assign rdata_o        = rdata_q;
  assign rdata_valid_o  = (state_q == StDone) && !is_store_q && !misal_q;
  assign misaligned_o   = (state_q == StDone) && misal_q;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: doc/cl_dmem_ctrl.md
# cl_dmem_ctrl

Sequences one core memory operation at a time onto the data-memory port and stalls the core until the operation completes. It sits between the decode/execute stage, which supplies the load/store/byte classification of the current instruction, and the data memory's valid/yumi request channel and rvalid response channel. It forms byte enables and lane replication for byte stores, zero-extends LBU results, rejects misaligned word accesses, and counts stall cycles.

## Interface
- No parameters. Address and data are fixed at 32 bits; the byte-enable bus is fixed at 4 bits.
- clk  in  1  — the single clock.
- reset  in  1  — synchronous, active-high reset.
- req_valid_i  in  1  — the current instruction is a memory op (load or store) and is valid in the stage.
- is_store_i  in  1  — 1 = store (SW/SB), 0 = load (LW/LBU).
- is_byte_i  in  1  — byte op (LBU/SB).
- addr_i  in  32  — byte address.
- wdata_i  in  32  — store data; bits [7:0] are used for SB.
- stall_o  out  1  — the core must hold the instruction and all inputs stable.
- rdata_o  out  32  — load result, valid while rdata_valid_o is high.
- rdata_valid_o  out  1  — single-cycle pulse, loads only.
- misaligned_o  out  1  — single-cycle pulse: a word op had addr_i[1:0] != 0.
- stall_cycles_o  out  32  — saturating count of cycles in which stall_o was 1.
- dmem_valid_o  out  1  — request to data memory.
- dmem_we_o  out  1  — write request.
- dmem_addr_o  out  30  — word address, equal to addr[31:2].
- dmem_wdata_o  out  32  — write data.
- dmem_be_o  out  4  — byte enables; bit i selects data bits [8i+7:8i].
- dmem_yumi_i  in  1  — memory accepts the request this cycle.
- dmem_rvalid_i  in  1  — read data valid.
- dmem_rdata_i  in  32  — read data.

## Operation
The FSM has four states: IDLE, REQ, WAIT, DONE.

**IDLE**
- When req_valid_i=1, register is_store, is_byte, addr and wdata.
- If the op is a word op and addr_i[1:0] != 0, go to DONE with the misaligned flag set and issue no memory access.
- Otherwise go to REQ.

**REQ**
- dmem_valid_o=1, driven from the registered fields.
- The registered fields stay constant until dmem_yumi_i=1.
- On yumi, a store goes to DONE and a load goes to WAIT.

**WAIT**
- On dmem_rvalid_i=1, register the formatted data and go to DONE.

**DONE**
- stall_o=0.
- rdata_valid_o=1 if the op was a load that was not misaligned.
- misaligned_o=1 if the flag is set.
- Next state is always IDLE. A req_valid_i seen in DONE is ignored, because the core advances in this cycle.

**stall_o (combinational)**
- (state==IDLE & req_valid_i) | state==REQ | state==WAIT.

**Byte formatting**
- Store word: be=4'hF, wdata=wdata.
- Store byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Load word: rdata = dmem_rdata_i.
- Load byte: rdata = {24'b0, dmem_rdata_i[8*addr[1:0] +: 8]}.
- dmem_we_o = registered is_store.
- When dmem_valid_o=0, dmem_we_o and dmem_be_o are 0.
- rdata_o holds its last value outside DONE. It is 0 after reset and after a misaligned op.

**Stall counter**
- Increments by 1 in each cycle with stall_o=1.
- Saturates at 32'hFFFF_FFFF.
- Cleared only by reset.

## Timing
- Reset values:
  - state = IDLE.
  - stall_o=0 unless req_valid_i=1.
  - All dmem_* outputs 0.
  - rdata_o=0, rdata_valid_o=0, misaligned_o=0, stall_cycles_o=0.
- Minimum store latency is 3 cycles: IDLE (capture), REQ (yumi), DONE.
- Minimum load latency is 4 cycles: IDLE, REQ (yumi), WAIT (rvalid), DONE.
- yumi in the same cycle as rvalid is not supported; rvalid is sampled only in WAIT.
- Each cycle without yumi adds one cycle in REQ. Each cycle without rvalid adds one cycle in WAIT. There is no timeout.
- dmem_rvalid_i outside WAIT is ignored (no state change, no data capture).
- dmem_yumi_i outside REQ is ignored.
- A misaligned op takes 2 cycles (IDLE, DONE) and raises dmem_valid_o in no cycle.
- Back-to-back memory ops: the next op is captured in the IDLE cycle after DONE, giving exactly one non-stalled cycle (DONE) between ops.
- Reset in any state, checked on the next edge:
  - Returns to IDLE and clears all registers and the counter.
  - Any pending memory response is dropped; a late rvalid is ignored per the rule above.
- Only one operation is ever outstanding.

## Test plan
- **SW with immediate yumi:** addr=0x100, wdata=0xDEADBEEF → one REQ cycle with dmem_addr_o=0x40, be=4'hF, we=1; stall_o high for 2 cycles; stall_cycles_o=2.
- **SB:** addr=0x103, wdata=0x000000A5 → be=4'b1000, dmem_wdata_o=0xA5A5A5A5.
- **LBU with delays:** addr=0x202, yumi after 2 cycles, rvalid after 3 more, dmem_rdata_i=0x11223344 → rdata_o=0x00000022 with rdata_valid_o pulsed once; stall_o high for 1+3+3 = 7 cycles.
- **LW misaligned:** addr=0x301 → misaligned_o pulses in cycle 2; dmem_valid_o is never 1; rdata_valid_o=0.
- **Spurious response and reset:** rvalid asserted while IDLE or REQ → no capture. Reset asserted in WAIT → next cycle all outputs are at their reset values; a late rvalid produces no rdata_valid_o.
- **Back-to-back and saturation:** back-to-back SW then LW → exactly one DONE cycle between the two REQ phases. Force stall_cycles_o near all-ones via a long yumi hold → the counter holds at 32'hFFFF_FFFF.
